// File: rtl/button_gesture.sv
// Per-button gesture classifier: short press, long press and auto-repeat pulses for 8 debounced buttons.
// Define BUTTON_GESTURE_REPEAT_EN to enable auto-repeat pulses while a long press is held.
module button_gesture #(
  parameter int LONG_CYCLES   = 50_000_000,
  parameter int REPEAT_CYCLES = 10_000_000,
  parameter int CNT_W         = 27
) (
  input  logic        clk,
  input  logic        power,
  input  logic [15:0] button,
  output logic [7:0]  short_press,
  output logic [7:0]  long_press,
  output logic [7:0]  repeat_press,
  output logic [7:0]  held
);

  // state | meaning
  // LOCK  | after reset; waits for a release so a button held through reset emits nothing
  // IDLE  | released, waiting for a press
  // HELD  | pressed, counting towards the long-press threshold
  // LONG  | long press reported; counting repeat intervals until release
  typedef enum logic [1:0] {
    LOCK = 2'd0,
    IDLE = 2'd1,
    HELD = 2'd2,
    LONG = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LONG_TC = CNT_W'(LONG_CYCLES - 1);
`ifdef BUTTON_GESTURE_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_TC  = CNT_W'(REPEAT_CYCLES - 1);
`else
  localparam int unused_repeat_cycles = REPEAT_CYCLES;
`endif

  // Press pulses from input_process are not needed here; levels carry everything.
  logic unused_pulses;
  assign unused_pulses = ^button[15:8];

  for (genvar i = 0; i < 8; i++) begin : g_btn
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             short_q, short_d;
    logic             long_q, long_d;
    logic             rep_q, rep_d;
    logic             held_q, held_d;
    logic             level;

    assign level = button[i];

    always_ff @(posedge clk or negedge power) begin
      if (!power) begin
        state_q <= LOCK;
        cnt_q   <= '0;
        short_q <= 1'b0;
        long_q  <= 1'b0;
        rep_q   <= 1'b0;
        held_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        short_q <= short_d;
        long_q  <= long_d;
        rep_q   <= rep_d;
        held_q  <= held_d;
      end
    end

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      short_d = 1'b0;
      long_d  = 1'b0;
      rep_d   = 1'b0;
      case (state_q)
        LOCK: begin
          cnt_d = '0;
          if (!level) state_d = IDLE;
        end
        IDLE: begin
          cnt_d = '0;
          if (level) begin
            state_d = HELD;
            cnt_d   = CNT_W'(1);
          end
        end
        HELD: begin
          // Release wins over reaching the threshold on the same edge.
          if (!level) begin
            state_d = IDLE;
            short_d = 1'b1;
            cnt_d   = '0;
          end else if (cnt_q == LONG_TC) begin
            state_d = LONG;
            long_d  = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        LONG: begin
          if (!level) begin
            state_d = IDLE;
            cnt_d   = '0;
`ifdef BUTTON_GESTURE_REPEAT_EN
          end else if (cnt_q == REP_TC) begin
            rep_d = 1'b1;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
`else
          end else begin
            cnt_d = '0;
          end
`endif
        end
        default: begin
          state_d = LOCK;
          cnt_d   = '0;
        end
      endcase
      held_d = (state_d == HELD) || (state_d == LONG);
    end

    assign short_press[i] = short_q;
    assign long_press[i]  = long_q;
    assign held[i]        = held_q;
`ifdef BUTTON_GESTURE_REPEAT_EN
    assign repeat_press[i] = rep_q;
`else
    logic unused_rep;
    assign unused_rep      = rep_q;
    assign repeat_press[i] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_button_gesture.sv
// Self-checking bench for button_gesture: gesture table with closed-form expectations plus reset corner sequences.
module tb_button_gesture;
  localparam int LONG_C = 10;
  localparam int REP_C  = 4;
`ifdef BUTTON_GESTURE_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        power = 1'b1;
  logic [15:0] button = '0;
  logic [7:0]  short_press, long_press, repeat_press, held;

  button_gesture #(
    .LONG_CYCLES  (LONG_C),
    .REPEAT_CYCLES(REP_C),
    .CNT_W        (27)
  ) dut (
    .clk         (clk),
    .power       (power),
    .button      (button),
    .short_press (short_press),
    .long_press  (long_press),
    .repeat_press(repeat_press),
    .held        (held)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] s;
    logic [7:0] l;
    logic [7:0] r;
    logic [7:0] h;
  } exp_t;

  typedef struct {
    logic [7:0] ma;
    int         la;
    logic [7:0] mb;
    int         lb;
  } gest_t;

  exp_t  sb_q[$];
  gest_t tbl[8];
  int    checks = 0;
  int    passed = 0;
  int    cyc = 0;

  task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s cycle %0d: got %02h expected %02h", name, cyc, act, exp);
  endtask

  // Drive one sample between edges; the expected outputs after that edge go to the scoreboard.
  task automatic step(input logic pwr, input logic [7:0] lvl, input exp_t e);
    exp_t g;
    power  = pwr;
    button = {8'($urandom), lvl};
    sb_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    cyc++;
    g = sb_q.pop_front();
    cmp("short_press", short_press, g.s);
    cmp("long_press", long_press, g.l);
    cmp("repeat_press", repeat_press, g.r);
    cmp("held", held, g.h);
  endtask

  // Expectations from sample index t (0-based) and hold length, starting from IDLE.
  function automatic exp_t gest_exp(input gest_t g, input int t);
    exp_t e;
    int   len;
    e = '0;
    for (int i = 0; i < 8; i++) begin
      len = g.ma[i] ? g.la : (g.mb[i] ? g.lb : 0);
      if (len > 0) begin
        if (t < len) e.h[i] = 1'b1;
        if (len >= LONG_C && t == LONG_C - 1) e.l[i] = 1'b1;
        if (len < LONG_C && t == len) e.s[i] = 1'b1;
        if (REP_EN && t >= LONG_C && t < len && ((t - (LONG_C - 1)) % REP_C) == 0) e.r[i] = 1'b1;
      end
    end
    return e;
  endfunction

  function automatic logic [7:0] gest_lvl(input gest_t g, input int t);
    logic [7:0] v;
    for (int i = 0; i < 8; i++)
      v[i] = (g.ma[i] && t < g.la) || (g.mb[i] && t < g.lb);
    return v;
  endfunction

  task automatic run_gesture(input gest_t g);
    int mx;
    mx = (g.la > g.lb) ? g.la : g.lb;
    for (int t = 0; t <= mx + 1; t++)
      step(1'b1, gest_lvl(g, t), gest_exp(g, t));
  endtask

  initial begin
    exp_t  z;
    gest_t g;
    z = '0;

    tbl[0] = '{ma: 8'h01, la: 9,  mb: 8'h00, lb: 0};
    tbl[1] = '{ma: 8'h01, la: 20, mb: 8'h00, lb: 0};
    tbl[2] = '{ma: 8'h04, la: 3,  mb: 8'h20, lb: 12};
    tbl[3] = '{ma: 8'h80, la: 1,  mb: 8'h00, lb: 0};
    tbl[4] = '{ma: 8'h10, la: 10, mb: 8'h00, lb: 0};
    tbl[5] = '{ma: 8'h40, la: 11, mb: 8'h01, lb: 9};
    tbl[6] = '{ma: 8'h0A, la: 25, mb: 8'h00, lb: 0};
    tbl[7] = '{ma: 8'hFF, la: 10, mb: 8'h00, lb: 0};

    #1 power = 1'b0;
    @(negedge clk);
    step(1'b0, 8'h00, z);
    step(1'b0, 8'h00, z);
    step(1'b1, 8'h00, z);

    for (int k = 0; k < 8; k++) run_gesture(tbl[k]);

    // Button held through reset release: locked out until it is released.
    for (int k = 0; k < 3; k++)  step(1'b0, 8'h08, z);
    for (int k = 0; k < 30; k++) step(1'b1, 8'h08, z);
    step(1'b1, 8'h00, z);
    g = '{ma: 8'h08, la: 3, mb: 8'h00, lb: 0};
    run_gesture(g);

    // Reset in the middle of a hold aborts the gesture silently.
    step(1'b1, 8'h02, '{s: 8'h00, l: 8'h00, r: 8'h00, h: 8'h02});
    step(1'b1, 8'h02, '{s: 8'h00, l: 8'h00, r: 8'h00, h: 8'h02});
    step(1'b0, 8'h02, z);
    step(1'b0, 8'h02, z);
    for (int k = 0; k < 12; k++) step(1'b1, 8'h02, z);
    step(1'b1, 8'h00, z);
    g = '{ma: 8'h02, la: 2, mb: 8'h00, lb: 0};
    run_gesture(g);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
